// File: rtl/slt_32_bit_pkg.sv
// Shared constants for the 32-bit set-less-than block.
//   DATA_W    : operand / result width
//   SLT_TRUE  : result value when a < b
//   SLT_FALSE : result value otherwise
package slt_32_bit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SLT_TRUE  = 32'd1;
  localparam logic [DATA_W-1:0] SLT_FALSE = 32'd0;

endpackage : slt_32_bit_pkg

// File: rtl/slt_32_bit_subtract.sv
// Purely combinational ripple subtractor: diff = a + ~b + 1.
// Ports:
//   a, b : operands (DATA_W bits)
//   diff : a - b modulo 2^DATA_W
//   c31  : carry into the MSB
//   c32  : carry out of the MSB (1 = no borrow)
module subtract_32_bit
  import slt_32_bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff,
  output logic              c31,
  output logic              c32
);

  logic [DATA_W-1:0] w_b_n;
  logic [DATA_W:0]   w_carry;

  // Carry-in of 1 completes the two's-complement negation of b.
  assign w_b_n      = ~b;
  assign w_carry[0] = 1'b1;

  // One full adder per bit; w_carry[i] is the carry into bit i.
  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign diff[i]      = a[i] ^ w_b_n[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_n[i]) | (w_carry[i] & (a[i] ^ w_b_n[i]));
  end

  assign c31 = w_carry[DATA_W-1];
  assign c32 = w_carry[DATA_W];

endmodule : subtract_32_bit

// File: rtl/slt_32_bit.sv
// Registered set-less-than: result = 1 when a < b, else 0, one cycle latency.
// Parameter:
//   SIGNED_CMP : 1 = two's-complement compare (slt), 0 = unsigned (sltu)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : qualifies a and b this cycle
//   a, b       : operands
//   result     : registered {31'b0, lt}, held when no new operands arrive
//   out_valid  : one-cycle pulse when result carries a new value
module slt_32_bit
  import slt_32_bit_pkg::*;
#(
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              out_valid
);

  logic [DATA_W-1:0] w_diff;
  logic              w_c31;
  logic              w_c32;
  logic              w_ovf;
  logic              w_lt;
  logic              w_unused;

  logic [DATA_W-1:0] r_result;
  logic              r_valid;

  subtract_32_bit u_sub (
    .a    (a),
    .b    (b),
    .diff (w_diff),
    .c31  (w_c31),
    .c32  (w_c32)
  );

  // Only the sign bit of the difference matters for the decision.
  assign w_unused = ^w_diff[DATA_W-2:0];

  // Signed: sign of diff corrected by overflow. Unsigned: borrow out.
  assign w_ovf = w_c31 ^ w_c32;
  assign w_lt  = SIGNED_CMP ? (w_diff[DATA_W-1] ^ w_ovf) : ~w_c32;

  // Result holds between transactions; valid pulses once per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= SLT_FALSE;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_lt ? SLT_TRUE : SLT_FALSE;
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_valid;

endmodule : slt_32_bit

// File: tb/tb_slt_32_bit.sv
// Self-checking bench: a signed and an unsigned instance share stimulus; a
// comparison-operator model is checked every cycle, plus literal vectors.
module tb_slt_32_bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result_s;
  logic        out_valid_s;
  logic [31:0] result_u;
  logic        out_valid_u;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Model state: what each instance must currently show.
  logic        m_valid;
  logic [31:0] m_res_s;
  logic [31:0] m_res_u;

  logic [31:0] s_a [7] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd6,
                           32'hFFFF_FFFA, 32'd7, 32'd8};
  logic [31:0] s_b [7] = '{32'd6, 32'd6, 32'hFFFF_FFFA, 32'd7,
                           32'hFFFF_FFF9, 32'd7, 32'd48};
  logic        s_e [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  logic [31:0] corner [5] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'hFFFF_FFFF};

  slt_32_bit #(.SIGNED_CMP(1'b1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result_s),
    .out_valid (out_valid_s)
  );

  slt_32_bit #(.SIGNED_CMP(1'b0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result_u),
    .out_valid (out_valid_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: language comparison operators, one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res_s <= 32'd0;
      m_res_u <= 32'd0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_res_s <= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        m_res_u <= (a < b) ? 32'd1 : 32'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("model_valid_s", 32'(out_valid_s), 32'(m_valid));
        chk("model_result_s", result_s, m_res_s);
        chk("model_valid_u", 32'(out_valid_u), 32'(m_valid));
        chk("model_result_u", result_u, m_res_u);
      end
    end
  end

  // One isolated transaction, checked one cycle after capture.
  task automatic run_one(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                         input bit use_u, input logic expv);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_valid"}, 32'(use_u ? out_valid_u : out_valid_s), 32'd1);
    chk(name, use_u ? result_u : result_s, {31'b0, expv});
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_result_s", result_s, 32'd0);
    chk("reset_valid_s", 32'(out_valid_s), 32'd0);
    chk("reset_result_u", result_u, 32'd0);
    chk("reset_valid_u", 32'(out_valid_u), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Signed single transactions.
    for (int i = 0; i < 7; i++) begin
      run_one($sformatf("signed_vec%0d", i), s_a[i], s_b[i], 1'b0, s_e[i]);
    end

    // Signed overflow corners.
    run_one("ovf_min_1",      32'h8000_0000, 32'd1,         1'b0, 1'b1);
    run_one("ovf_max_m1",     32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_one("ovf_max_min",    32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    run_one("ovf_min_max",    32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Unsigned vectors.
    run_one("u_allones_1",    32'hFFFF_FFFF, 32'd1,         1'b1, 1'b0);
    run_one("u_1_allones",    32'd1,         32'hFFFF_FFFF, 1'b1, 1'b1);
    run_one("u_zero_zero",    32'd0,         32'd0,         1'b1, 1'b0);
    run_one("u_min_max",      32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);

    // Streaming: seven back-to-back operands, then a gap.
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("stream_valid%0d", k - 1), 32'(out_valid_s), 32'd1);
        chk($sformatf("stream_result%0d", k - 1), result_s, {31'b0, s_e[k-1]});
      end
      if (k < 7) begin
        a        = s_a[k];
        b        = s_b[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("gap_valid", 32'(out_valid_s), 32'd0);
    chk("gap_result_held", result_s, 32'd1);

    // Reset mid-stream right after a capture of result=1.
    a        = 32'hFFFF_FFF9;
    b        = 32'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("pre_reset_result", result_s, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_result", result_s, 32'd0);
    chk("async_reset_valid", 32'(out_valid_s), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_valid%0d", k), 32'(out_valid_s), 32'd0);
      chk($sformatf("post_reset_result%0d", k), result_s, 32'd0);
    end

    // Random operands with corner biasing and occasional bubbles.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      in_valid = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_slt_32_bit
